// File: rtl/neurosync_pkg.sv
// rtl/neurosync_pkg.sv - shared constants and helpers for the neurosync input conditioner
package neurosync_pkg;

  localparam int N_INPUTS            = 9;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int CNT_W               = 20;

  localparam int IDX_JOGAR    = 0;
  localparam int IDX_CONFIRMA = 1;
  localparam int IDX_RESET    = 2;
  localparam int IDX_DIREITA  = 3;
  localparam int IDX_ESQUERDA = 4;
  localparam int IDX_BOTOES   = 5;

  // Lowest set bit wins when several answer buttons qualify together.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/neurosync_input_channel.sv
// rtl/neurosync_input_channel.sv - one button channel: synchronizer, debounce counter, press pulse
module neurosync_input_channel
  import neurosync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic det_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic             det_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any disagreement with the stable level must persist unbroken for the full window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise_o  = stable_q & ~prev_q;
  assign level_o = stable_q;
  assign det_o   = det_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      det_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      det_q    <= rise_o;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/neurosync_input_conditioner.sv
// rtl/neurosync_input_conditioner.sv - debounces nine push-buttons into levels and press pulses
module neurosync_input_conditioner
  import neurosync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       confirma,
  input  logic       reset_btn,
  input  logic       direita,
  input  logic       esquerda,
  input  logic [3:0] botoes,
  output logic       jogar_det,
  output logic       confirma_det,
  output logic       reset_det,
  output logic       direita_det,
  output logic       esquerda_det,
  output logic [3:0] botoes_det,
  output logic [8:0] niveis,
  output logic       botao_valido,
  output logic [1:0] botao_idx
);

  logic [N_INPUTS-1:0] raw;
  logic [N_INPUTS-1:0] level;
  logic [N_INPUTS-1:0] rise;
  logic [N_INPUTS-1:0] det;

  logic       botao_valido_q, botao_valido_d;
  logic [1:0] botao_idx_q, botao_idx_d;

  assign raw = {botoes, esquerda, direita, reset_btn, confirma, jogar};

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
    neurosync_input_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i  (clock),
      .rst_ni (reset),
      .raw_i  (raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g]),
      .det_o  (det[g])
    );
  end

  // Registered from the same rise terms as the channel pulses so they line up with botoes_det.
  always_comb begin
    botao_valido_d = |rise[IDX_BOTOES +: 4];
    botao_idx_d    = botao_idx_q;
    if (botao_valido_d) begin
      botao_idx_d = lowest_set(rise[IDX_BOTOES +: 4]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botao_valido_q <= 1'b0;
      botao_idx_q    <= 2'd0;
    end else begin
      botao_valido_q <= botao_valido_d;
      botao_idx_q    <= botao_idx_d;
    end
  end

  assign jogar_det    = det[IDX_JOGAR];
  assign confirma_det = det[IDX_CONFIRMA];
  assign reset_det    = det[IDX_RESET];
  assign direita_det  = det[IDX_DIREITA];
  assign esquerda_det = det[IDX_ESQUERDA];
  assign botoes_det   = det[IDX_BOTOES +: 4];
  assign niveis       = level;
  assign botao_valido = botao_valido_q;
  assign botao_idx    = botao_idx_q;

endmodule

// File: tb/tb_neurosync_input_conditioner.sv
// tb/tb_neurosync_input_conditioner.sv - directed self-checking bench for the input conditioner
module tb_neurosync_input_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar, confirma, reset_btn, direita, esquerda;
  logic [3:0] botoes;
  logic       jogar_det, confirma_det, reset_det, direita_det, esquerda_det;
  logic [3:0] botoes_det;
  logic [8:0] niveis;
  logic       botao_valido;
  logic [1:0] botao_idx;

  logic [8:0] det_vec;
  logic [8:0] niv_seen;
  int         pulse_cnt [9];
  int         n_assert = 0;
  int         n_fail   = 0;

  neurosync_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .jogar       (jogar),
    .confirma    (confirma),
    .reset_btn   (reset_btn),
    .direita     (direita),
    .esquerda    (esquerda),
    .botoes      (botoes),
    .jogar_det   (jogar_det),
    .confirma_det(confirma_det),
    .reset_det   (reset_det),
    .direita_det (direita_det),
    .esquerda_det(esquerda_det),
    .botoes_det  (botoes_det),
    .niveis      (niveis),
    .botao_valido(botao_valido),
    .botao_idx   (botao_idx)
  );

  always #5 clock = ~clock;

  assign det_vec = {botoes_det, esquerda_det, direita_det, reset_det, confirma_det, jogar_det};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      for (int c = 0; c < 9; c++) if (det_vec[c]) pulse_cnt[c]++;
      niv_seen |= niveis;
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 9; c++) pulse_cnt[c] = 0;
    niv_seen = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    jogar = 1'b0; confirma = 1'b0; reset_btn = 1'b0;
    direita = 1'b0; esquerda = 1'b0; botoes = 4'b0;
    clear_stats();
    tick(2);
    check("rst_niveis", 32'(niveis), 32'h0);
    check("rst_det", 32'(det_vec), 32'h0);
    check("rst_valido", 32'(botao_valido), 32'h0);
    check("rst_idx", 32'(botao_idx), 32'h0);
    reset = 1'b1;
    tick(3);

    // jogar held: pulse right after edge 6, level from edge 5, one pulse only
    clear_stats();
    jogar = 1'b1;
    tick(5);
    check("jogar_lvl_e4", 32'(niveis[0]), 32'h0);
    check("jogar_det_e4", 32'(jogar_det), 32'h0);
    tick(1);
    check("jogar_lvl_e5", 32'(niveis[0]), 32'h1);
    check("jogar_det_e5", 32'(jogar_det), 32'h0);
    tick(1);
    check("jogar_det_e6", 32'(jogar_det), 32'h1);
    tick(1);
    check("jogar_det_e7", 32'(jogar_det), 32'h0);
    tick(50);
    check("jogar_one_pulse", 32'(pulse_cnt[0]), 32'd1);

    // release: level clears after edge 5, no pulse on the fall
    jogar = 1'b0;
    tick(5);
    check("jogar_fall_e4", 32'(niveis[0]), 32'h1);
    tick(1);
    check("jogar_fall_e5", 32'(niveis[0]), 32'h0);
    tick(10);
    check("jogar_no_fall_pulse", 32'(pulse_cnt[0]), 32'd1);

    // confirma chattering every cycle never qualifies
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      confirma = ~i[0];
      tick(1);
    end
    confirma = 1'b0;
    tick(10);
    check("confirma_pulses", 32'(pulse_cnt[1]), 32'd0);
    check("confirma_level", 32'(niv_seen[1]), 32'd0);

    // two answer buttons together: lowest index reported
    clear_stats();
    botoes = 4'b1010;
    tick(6);
    check("botoes_det_e5", 32'(botoes_det), 32'h0);
    tick(1);
    check("botoes_det_e6", 32'(botoes_det), 32'ha);
    check("valido_e6", 32'(botao_valido), 32'h1);
    check("idx_e6", 32'(botao_idx), 32'h1);
    tick(1);
    check("botoes_det_e7", 32'(botoes_det), 32'h0);
    check("valido_e7", 32'(botao_valido), 32'h0);
    botoes = 4'b0000;
    tick(10);
    check("idx_hold", 32'(botao_idx), 32'h1);
    check("botoes_level_off", 32'(niveis[8:5]), 32'h0);
    botoes = 4'b1000;
    tick(7);
    check("valido_b3", 32'(botao_valido), 32'h1);
    check("idx_b3", 32'(botao_idx), 32'h3);
    botoes = 4'b0000;
    tick(10);

    // direita: short press rejected, long press yields exactly one pulse
    clear_stats();
    direita = 1'b1;
    tick(3);
    direita = 1'b0;
    tick(10);
    check("direita_short", 32'(pulse_cnt[3]), 32'd0);
    check("direita_short_lvl", 32'(niv_seen[3]), 32'd0);
    direita = 1'b1;
    tick(8);
    direita = 1'b0;
    tick(10);
    check("direita_long", 32'(pulse_cnt[3]), 32'd1);

    // esquerda: reset mid-count, still held through release
    clear_stats();
    esquerda = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    check("midrst_det", 32'(det_vec), 32'h0);
    check("midrst_niveis", 32'(niveis), 32'h0);
    tick(2);
    check("midrst_det2", 32'(det_vec), 32'h0);
    check("midrst_valido", 32'(botao_valido), 32'h0);
    check("midrst_idx", 32'(botao_idx), 32'h0);
    reset = 1'b1;
    clear_stats();
    tick(6);
    check("esq_det_e5", 32'(esquerda_det), 32'h0);
    tick(1);
    check("esq_det_e6", 32'(esquerda_det), 32'h1);
    check("esq_level", 32'(niveis[4]), 32'h1);
    esquerda = 1'b0;
    tick(10);
    check("esq_one_pulse", 32'(pulse_cnt[4]), 32'd1);
    check("reset_btn_quiet", 32'(pulse_cnt[2]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/neurosync_input_conditioner.md
NEUROSYNC_INPUT_CONDITIONER -- requirements
Module: neurosync_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning cycles an input must hold a new level before acceptance (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset of all state.
REQ-004 SHALL have port jogar, confirma, reset_btn, direita, esquerda  input  1 each  raw asynchronous push-button levels, active-high.
REQ-005 SHALL have port botoes  input  4  raw asynchronous answer buttons, active-high.
REQ-006 SHALL have port jogar_det, confirma_det, reset_det, direita_det, esquerda_det  output  1 each  one-cycle press pulses.
REQ-007 SHALL have port botoes_det  output  4  one-cycle press pulse per answer button.
REQ-008 SHALL have port niveis  output  9  debounced levels, bit order {botoes[3:0], esquerda, direita, reset_btn, confirma, jogar} (bit 0 = jogar).
REQ-009 SHALL have port botao_valido  output  1  pulse, high when any botoes_det bit is high.
REQ-010 SHALL have port botao_idx  output  2  index of the pressed answer button, held until the next botao_valido.

Function
REQ-011 SHALL pass each of the 9 inputs through a 2-flop synchronizer before any other logic.
REQ-012 SHALL keep per channel a stable level and a 20-bit mismatch counter; counter increments each cycle the synchronized input differs from the stable level and clears to 0 whenever they match.
REQ-013 SHALL, on the edge where a mismatching counter equals DEBOUNCE_CYCLES-1, update the stable level to the synchronized input and clear the counter.
REQ-014 SHALL assert the channel's _det output for exactly one cycle: the first cycle the stable level reads 1 after being 0. Latency is DEBOUNCE_CYCLES+2 rising edges from the first edge sampling the raw high.
REQ-015 SHALL generate no pulse on a stable 1->0 transition.
REQ-016 SHALL discard any raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles; the counter restarts from 0 on each bounce.
REQ-017 SHALL produce at most one pulse per press, however long the button is held.
REQ-018 SHALL pulse every channel independently; simultaneous qualifying channels pulse in the same cycle.
REQ-019 SHALL register botao_valido and botao_idx in the same cycle as botoes_det; on simultaneous answer pulses, botao_idx selects the lowest index.
REQ-020 SHALL drive niveis directly from the stable levels, with no extra delay.

Reset
REQ-021 SHALL, while reset=0, clear synchronizers, counters, stable levels, all _det outputs, botao_valido, niveis and botao_idx to 0.
REQ-022 SHALL, if reset asserts mid-count, abandon the count; a button held through reset release pulses DEBOUNCE_CYCLES+2 edges after release.
REQ-023 SHALL treat reset_btn as an ordinary debounced channel; it has no effect on this block's own state.

Structure
REQ-024 SHALL take N_INPUTS=9, the DEBOUNCE_CYCLES default, the counter width and the niveis bit-index constants from the shared package neurosync_pkg.
REQ-025 SHALL implement one channel (synchronizer, counter, stable level, pulse) as sub-module neurosync_input_channel, instantiated 9 times via generate.
REQ-026 SHALL contain no combinational path from any raw input to any output.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover: jogar held high from edge 0 -> jogar_det high only in the cycle after edge 6, niveis[0]=1 from then; no further pulse while held 50 cycles.
REQ-028 SHALL cover: confirma toggling 1,0,1,0 every cycle for 10 cycles then low -> confirma_det never asserts, niveis[1] stays 0.
REQ-029 SHALL cover: botoes=4'b1010 rising together -> botoes_det=4'b1010 for one cycle, botao_valido=1, botao_idx=1; botao_idx holds 1 after botoes released.
REQ-030 SHALL cover: direita held for 3 cycles then released -> direita_det stays 0; the same button held for 8 cycles -> exactly one pulse.
REQ-031 SHALL cover: esquerda high, reset pulled low 2 cycles into counting, released with esquerda still high -> all outputs 0 during reset; esquerda_det pulses 6 edges after release.
REQ-032 SHALL cover: jogar stable high, then low for 10 cycles -> no pulse on release; niveis[0] clears 6 edges after the fall.
